ahb_arbiter: RTL

Round-robin bus arbiter that shares the single AHB address/data bus between up to four masters. It sits beside the decoder and multiplexer in the bus fabric. It registers one-hot grants, tracks burst length so a fixed-length burst is never split, and honours locked sequences. It publishes the address-phase owner (`Hmaster`) and the data-phase owner (`Hmaster_data`) so the fabric can steer the write-data and response paths.

---
 rtl/ahb_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter for up to four masters: registered one-hot grant,
// fixed-burst protection, locked sequences and address/data-phase owner tracking.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic       Hclk,
    input  logic       Hreset,
    input  logic [3:0] Hbusreq,
    input  logic [3:0] Hlock,
    input  logic [1:0] Htrans,
    input  logic [2:0] Hburst,
    input  logic       Hready,
    input  logic       Hresp,
    output logic [3:0] Hgrant,
    output logic [1:0] Hmaster,
    output logic [1:0] Hmaster_data,
    output logic       Hmastlock
);

    typedef enum logic [1:0] {PARK, OWNED, BURST, LOCKED} state_e;

    localparam logic [1:0] TR_IDLE    = 2'd0;
    localparam logic [1:0] TR_NONSEQ  = 2'd2;
    localparam logic [1:0] TR_SEQ     = 2'd3;
    localparam logic [2:0] BURST_INCR = 3'd1;

    localparam logic [1:0] DEF_MASTER = 2'(DEFAULT_MASTER);
    localparam logic [3:0] DEF_GRANT  = 4'(1 << DEFAULT_MASTER);
    localparam logic [3:0] REQ_MASK   = 4'((1 << NUM_MASTERS) - 1);

    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] mdata_q, mdata_d;
    logic       mastlock_q, mastlock_d;
    logic [3:0] beats_q, beats_d;
    logic       err_q, err_d;

    logic [3:0] req_valid;
    logic [1:0] winner;
    logic       any_req;
    logic       lock_hold;
    logic       arb_rule;

    function automatic logic [3:0] last_beat(input logic [2:0] burst);
        case (burst)
            3'd2, 3'd3: return 4'd3;
            3'd4, 3'd5: return 4'd7;
            3'd6, 3'd7: return 4'd15;
            default:    return 4'd0;
        endcase
    endfunction

    assign req_valid = Hbusreq & REQ_MASK;

    // Walk the rotation backwards so the last hit is the first master after the owner.
    always_comb begin
        logic [1:0] cand;
        cand    = '0;
        winner  = DEF_MASTER;
        any_req = 1'b0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            cand = 2'((int'(owner_q) + i) % NUM_MASTERS);
            if (req_valid[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every combinational output is given a default first so no path infers a latch.
        state_d    = state_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        mdata_d    = mdata_q;
        mastlock_d = mastlock_q;
        beats_d    = beats_q;
        err_d      = err_q;
        lock_hold  = 1'b0;
        arb_rule   = 1'b0;

        if (Hready) begin
            mdata_d = owner_q;
            err_d   = 1'b0;
            if (Htrans == TR_NONSEQ) begin
                beats_d = last_beat(Hburst);
            end else if (Htrans == TR_SEQ) begin
                beats_d = (beats_q == 4'd0) ? 4'd0 : beats_q - 4'd1;
            end

            // A lock taken with this NONSEQ, or still held, suppresses arbitration.
            lock_hold = Hlock[owner_q] && (state_q == LOCKED || Htrans == TR_NONSEQ);
            arb_rule  = err_q
                     || (Htrans == TR_IDLE)
                     || (Htrans[1] && beats_d == 4'd0 && Hburst != BURST_INCR)
                     || (Hburst == BURST_INCR && !Hbusreq[owner_q]);

            if (lock_hold) begin
                state_d    = LOCKED;
                mastlock_d = 1'b1;
            end else begin
                mastlock_d = 1'b0;
                if (arb_rule) begin
                    owner_d = winner;
                    grant_d = 4'b0001 << winner;
                    if (!any_req)               state_d = PARK;
                    else if (beats_d != 4'd0)   state_d = BURST;
                    else                        state_d = OWNED;
                end else begin
                    state_d = (beats_d != 4'd0) ? BURST : OWNED;
                end
            end
        end else if (Hresp) begin
            beats_d = 4'd0;
            err_d   = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q    <= PARK;
            owner_q    <= DEF_MASTER;
            grant_q    <= DEF_GRANT;
            mdata_q    <= DEF_MASTER;
            mastlock_q <= 1'b0;
            beats_q    <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            mdata_q    <= mdata_d;
            mastlock_q <= mastlock_d;
            beats_q    <= beats_d;
            err_q      <= err_d;
        end
    end

    assign Hgrant       = grant_q;
    assign Hmaster      = owner_q;
    assign Hmaster_data = mdata_q;
    assign Hmastlock    = mastlock_q;

endmodule
